memoria_padroes: RTL and testbench



---
 rtl/memoria_padroes_if.sv | 29 ++
 rtl/memoria_padroes.sv | 127 ++++++++++++
 tb/tb_memoria_padroes.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/memoria_padroes_if.sv
// Host-side bundle for the pattern-memory sequencer: opcode, table write
// port, wrap point, and the registered outputs it presents.
interface memoria_padroes_if #(
   parameter int WIDTH = 5,
   parameter int AW    = 2,
   parameter int EW    = 4
);
   logic [1:0]       Tx;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic [AW-1:0]    ultimo;
   logic [WIDTH-1:0] entrada;
   logic [AW-1:0]    contador;
   logic [EW-1:0]    etapa;
   logic             fim;

   // Host side: drives opcode/table port, observes the sequencer.
   modport master (
      output Tx, wr_en, wr_addr, wr_data, ultimo,
      input  entrada, contador, etapa, fim
   );

   // Sequencer side.
   modport slave (
      input  Tx, wr_en, wr_addr, wr_data, ultimo,
      output entrada, contador, etapa, fim
   );
endinterface

// File: rtl/memoria_padroes.sv
// Pattern-memory sequencer: presents words from a programmable table on
// `entrada` under the shared Tx opcode, with a programmable wrap point,
// in-place left shift, a pass counter and a one-cycle wrap pulse.
module memoria_padroes #(
   parameter int WIDTH     = 5,
   parameter int DEPTH     = 4,
   parameter int AW        = 2,
   parameter int EW        = 4,
   parameter int RESET_VAL = 2
) (
   input logic               clock,
   input logic               reset,
   memoria_padroes_if.slave  bus
);

   typedef enum logic [1:0] {
      OP_RESET  = 2'b00,
      OP_LOAD   = 2'b01,
      OP_HOLD   = 2'b10,
      OP_SHIFTL = 2'b11
   } op_e;

   localparam int               IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH - 1);
   localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(RESET_VAL);

   op_e              op;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [WIDTH-1:0] entrada_q, entrada_d;
   logic [AW-1:0]    contador_q, contador_d;
   logic [EW-1:0]    etapa_q, etapa_d;
   logic             fim_q, fim_d;
   logic [AW-1:0]    last_eff;
   logic [WIDTH-1:0] rd_word;
   logic             wr_hit;
   logic             rd_ok;

   assign op = op_e'(bus.Tx);

   // Effective wrap point, clamped to the last physical entry.
   always_comb begin
      last_eff = (bus.ultimo > LAST_IDX) ? LAST_IDX : bus.ultimo;
   end

   // Table read at the pointer; reads the pre-edge contents, so a same-cycle
   // write to that address is only seen on the next pass.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      rd_word = '0;
      rd_ok   = (int'(contador_q) < DEPTH);
      if (rd_ok) begin
         rd_word = mem_q[contador_q[IW-1:0]];
      end
   end

   // Table write port: out-of-range addresses and writes during reset are dropped.
   always_comb begin
      mem_d  = mem_q;
      wr_hit = bus.wr_en && !reset && (int'(bus.wr_addr) < DEPTH);
      if (wr_hit) begin
         mem_d[bus.wr_addr[IW-1:0]] = bus.wr_data;
      end
   end

   // Opcode decode: next presented word, pointer, pass counter and wrap pulse.
   always_comb begin
      entrada_d  = entrada_q;
      contador_d = contador_q;
      etapa_d    = etapa_q;
      fim_d      = 1'b0;
      unique case (op)
         OP_RESET: begin
            entrada_d  = INIT_VAL;
            contador_d = '0;
            etapa_d    = '0;
         end
         OP_LOAD: begin
            entrada_d = rd_word;
            if (contador_q >= last_eff) begin
               contador_d = '0;
               etapa_d    = etapa_q + EW'(1);
               fim_d      = 1'b1;
            end else begin
               contador_d = contador_q + AW'(1);
            end
         end
         OP_HOLD: begin
            entrada_d = entrada_q;
         end
         OP_SHIFTL: begin
            entrada_d = {entrada_q[WIDTH-2:0], 1'b0};
         end
         default: begin
            entrada_d = entrada_q;
         end
      endcase
   end

   // Sequencer registers with synchronous reset taking priority over Tx.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (reset) begin
         entrada_q  <= INIT_VAL;
         contador_q <= '0;
         etapa_q    <= '0;
         fim_q      <= 1'b0;
      end else begin
         entrada_q  <= entrada_d;
         contador_q <= contador_d;
         etapa_q    <= etapa_d;
         fim_q      <= fim_d;
      end
   end

   // Pattern table storage.
   always_ff @(posedge clock) begin
      // NOTE: the table is deliberately not reset; it is retained across reset and undefined until written.
      mem_q <= mem_d;
   end

   assign bus.entrada  = entrada_q;
   assign bus.contador = contador_q;
   assign bus.etapa    = etapa_q;
   assign bus.fim      = fim_q;

endmodule

// File: tb/tb_memoria_padroes.sv
// Directed self-checking bench for memoria_padroes. AW=3 so that an
// out-of-range write address and an out-of-range ultimo are expressible.
module tb_memoria_padroes;

   localparam int WIDTH = 5;
   localparam int DEPTH = 4;
   localparam int AW    = 3;
   localparam int EW    = 4;

   localparam logic [1:0] T_RESET  = 2'b00;
   localparam logic [1:0] T_LOAD   = 2'b01;
   localparam logic [1:0] T_HOLD   = 2'b10;
   localparam logic [1:0] T_SHIFTL = 2'b11;

   logic clock;
   logic reset;
   int   n_vec;
   int   n_miss;

   memoria_padroes_if #(.WIDTH(WIDTH), .AW(AW), .EW(EW)) bus ();

   memoria_padroes #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .EW(EW), .RESET_VAL(2)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One clock with the given opcode and optional write; outputs sampled 1 time unit after the edge.
   task automatic cyc(input logic [1:0] op, input logic we, input logic [AW-1:0] a,
                      input logic [WIDTH-1:0] d);
      bus.Tx      = op;
      bus.wr_en   = we;
      bus.wr_addr = a;
      bus.wr_data = d;
      @(posedge clock);
      #1;
      bus.wr_en = 1'b0;
      bus.Tx    = T_HOLD;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(T_HOLD, 1'b0, '0, '0);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc(T_LOAD, 1'b0, '0, '0);
      reset = 1'b0;
      n_vec++;
      if (bus.entrada !== 5'd2) begin
         $display("FAIL reset_entrada: got %0d expected 2", bus.entrada); n_miss++;
      end
      n_vec++;
      if (bus.contador !== 3'd0 || bus.etapa !== 4'd0 || bus.fim !== 1'b0) begin
         $display("FAIL reset_regs: got contador=%0d etapa=%0d fim=%0d expected 0 0 0",
                  bus.contador, bus.etapa, bus.fim); n_miss++;
      end
   endtask

   task automatic test_legacy();
      logic [WIDTH-1:0] exp_w [7];
      logic             exp_f [7];
      exp_w = '{5'd3, 5'd4, 5'd2, 5'd3, 5'd4, 5'd2, 5'd3};
      exp_f = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      cyc(T_HOLD, 1'b1, 3'd0, 5'd3);
      cyc(T_HOLD, 1'b1, 3'd1, 5'd4);
      cyc(T_HOLD, 1'b1, 3'd2, 5'd2);
      cyc(T_HOLD, 1'b1, 3'd3, 5'd17);
      bus.ultimo = 3'd2;
      for (int i = 0; i < 7; i++) begin
         cyc(T_LOAD, 1'b0, '0, '0);
         n_vec++;
         if (bus.entrada !== exp_w[i] || bus.fim !== exp_f[i]) begin
            $display("FAIL legacy[%0d]: got entrada=%0d fim=%0d expected %0d %0d",
                     i, bus.entrada, bus.fim, exp_w[i], exp_f[i]); n_miss++;
         end
      end
      n_vec++;
      if (bus.etapa !== 4'd2 || bus.contador !== 3'd1) begin
         $display("FAIL legacy_end: got etapa=%0d contador=%0d expected 2 1",
                  bus.etapa, bus.contador); n_miss++;
      end
   endtask

   task automatic test_hold_shiftl();
      logic [WIDTH-1:0] exp_s [3];
      exp_s = '{5'd6, 5'd12, 5'd24};
      for (int i = 0; i < 3; i++) begin
         cyc(T_SHIFTL, 1'b0, '0, '0);
         n_vec++;
         if (bus.entrada !== exp_s[i] || bus.contador !== 3'd1 || bus.fim !== 1'b0) begin
            $display("FAIL shiftl[%0d]: got entrada=%0d contador=%0d fim=%0d expected %0d 1 0",
                     i, bus.entrada, bus.contador, bus.fim, exp_s[i]); n_miss++;
         end
      end
      cyc(T_HOLD, 1'b0, '0, '0);
      n_vec++;
      if (bus.entrada !== 5'd24 || bus.contador !== 3'd1 || bus.etapa !== 4'd2) begin
         $display("FAIL hold: got entrada=%0d contador=%0d etapa=%0d expected 24 1 2",
                  bus.entrada, bus.contador, bus.etapa); n_miss++;
      end
      cyc(T_LOAD, 1'b0, '0, '0);
      n_vec++;
      if (bus.entrada !== 5'd4 || bus.contador !== 3'd2) begin
         $display("FAIL load_after_shift: got entrada=%0d contador=%0d expected 4 2",
                  bus.entrada, bus.contador); n_miss++;
      end
   endtask

   task automatic test_reset_midpass();
      cyc(T_LOAD, 1'b0, '0, '0);   // presents 2, wraps, etapa 3
      cyc(T_LOAD, 1'b0, '0, '0);   // presents 3, contador 1
      n_vec++;
      if (bus.contador !== 3'd1 || bus.etapa !== 4'd3) begin
         $display("FAIL midpass_setup: got contador=%0d etapa=%0d expected 1 3",
                  bus.contador, bus.etapa); n_miss++;
      end
      // reset overrides LOAD and discards the simultaneous write
      reset = 1'b1;
      cyc(T_LOAD, 1'b1, 3'd0, 5'd30);
      reset = 1'b0;
      n_vec++;
      if (bus.entrada !== 5'd2 || bus.contador !== 3'd0 || bus.etapa !== 4'd0 || bus.fim !== 1'b0) begin
         $display("FAIL midpass_reset: got %0d %0d %0d %0d expected 2 0 0 0",
                  bus.entrada, bus.contador, bus.etapa, bus.fim); n_miss++;
      end
      cyc(T_LOAD, 1'b0, '0, '0);
      n_vec++;
      if (bus.entrada !== 5'd3) begin
         $display("FAIL table_retained: got %0d expected 3", bus.entrada); n_miss++;
      end
      // RESET opcode: same register effect, but the write lands
      cyc(T_RESET, 1'b1, 3'd0, 5'd9);
      n_vec++;
      if (bus.entrada !== 5'd2 || bus.contador !== 3'd0 || bus.etapa !== 4'd0 || bus.fim !== 1'b0) begin
         $display("FAIL op_reset: got %0d %0d %0d %0d expected 2 0 0 0",
                  bus.entrada, bus.contador, bus.etapa, bus.fim); n_miss++;
      end
      cyc(T_LOAD, 1'b0, '0, '0);
      n_vec++;
      if (bus.entrada !== 5'd9 || bus.contador !== 3'd1) begin
         $display("FAIL op_reset_write: got entrada=%0d contador=%0d expected 9 1",
                  bus.entrada, bus.contador); n_miss++;
      end
      cyc(T_HOLD, 1'b1, 3'd0, 5'd3);
   endtask

   task automatic test_collision();
      // contador=1, mem = 3,4,2,17
      cyc(T_LOAD, 1'b1, 3'd1, 5'd7);
      n_vec++;
      if (bus.entrada !== 5'd4) begin
         $display("FAIL collision_old: got %0d expected 4", bus.entrada); n_miss++;
      end
      cyc(T_LOAD, 1'b0, '0, '0);   // 2, wrap
      cyc(T_LOAD, 1'b0, '0, '0);   // 3
      n_vec++;
      if (bus.entrada !== 5'd3) begin
         $display("FAIL collision_pass: got %0d expected 3", bus.entrada); n_miss++;
      end
      cyc(T_LOAD, 1'b0, '0, '0);
      n_vec++;
      if (bus.entrada !== 5'd7) begin
         $display("FAIL collision_new: got %0d expected 7", bus.entrada); n_miss++;
      end
   endtask

   task automatic test_wrap_point();
      logic [WIDTH-1:0] exp_w [5];
      logic             exp_f [5];
      logic [AW-1:0]    ult [2];
      exp_w = '{5'd3, 5'd7, 5'd2, 5'd17, 5'd3};
      exp_f = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      ult   = '{3'd3, 3'd6};
      // ultimo=3 and an over-range ultimo both give the full 4-word cycle
      for (int u = 0; u < 2; u++) begin
         do_reset();
         bus.ultimo = ult[u];
         for (int i = 0; i < 5; i++) begin
            cyc(T_LOAD, 1'b0, '0, '0);
            n_vec++;
            if (bus.entrada !== exp_w[i] || bus.fim !== exp_f[i]) begin
               $display("FAIL wrap_u%0d[%0d]: got entrada=%0d fim=%0d expected %0d %0d",
                        ult[u], i, bus.entrada, bus.fim, exp_w[i], exp_f[i]); n_miss++;
            end
         end
      end
      // lower ultimo below the pointer mid-pass
      do_reset();
      bus.ultimo = 3'd3;
      for (int i = 0; i < 3; i++) cyc(T_LOAD, 1'b0, '0, '0);
      bus.ultimo = 3'd1;
      cyc(T_LOAD, 1'b0, '0, '0);
      n_vec++;
      if (bus.entrada !== 5'd17 || bus.fim !== 1'b1 || bus.contador !== 3'd0) begin
         $display("FAIL lower_ultimo: got entrada=%0d fim=%0d contador=%0d expected 17 1 0",
                  bus.entrada, bus.fim, bus.contador); n_miss++;
      end
      cyc(T_LOAD, 1'b0, '0, '0);
      cyc(T_LOAD, 1'b0, '0, '0);
      n_vec++;
      if (bus.entrada !== 5'd7 || bus.fim !== 1'b1 || bus.contador !== 3'd0) begin
         $display("FAIL lower_ultimo_pass: got entrada=%0d fim=%0d contador=%0d expected 7 1 0",
                  bus.entrada, bus.fim, bus.contador); n_miss++;
      end
   endtask

   task automatic test_back_to_back();
      // ultimo=0: back-to-back LOADs each wrap; pass counter rolls over
      logic [EW-1:0] exp_e;
      do_reset();
      bus.ultimo = 3'd0;
      for (int i = 0; i < 17; i++) begin
         cyc(T_LOAD, 1'b0, '0, '0);
         exp_e = EW'((i + 1) % 16);
         n_vec++;
         if (bus.entrada !== 5'd3 || bus.fim !== 1'b1 || bus.etapa !== exp_e || bus.contador !== 3'd0) begin
            $display("FAIL rollover[%0d]: got entrada=%0d fim=%0d etapa=%0d contador=%0d expected 3 1 %0d 0",
                     i, bus.entrada, bus.fim, bus.etapa, bus.contador, exp_e); n_miss++;
         end
      end
      cyc(T_HOLD, 1'b0, '0, '0);
      n_vec++;
      if (bus.fim !== 1'b0 || bus.etapa !== 4'd1) begin
         $display("FAIL rollover_hold: got fim=%0d etapa=%0d expected 0 1", bus.fim, bus.etapa); n_miss++;
      end
   endtask

   task automatic test_oor_write();
      logic [WIDTH-1:0] exp_w [4];
      exp_w = '{5'd3, 5'd7, 5'd2, 5'd17};
      cyc(T_HOLD, 1'b1, 3'd5, 5'd31);
      cyc(T_HOLD, 1'b1, 3'd4, 5'd30);
      do_reset();
      bus.ultimo = 3'd3;
      for (int i = 0; i < 4; i++) begin
         cyc(T_LOAD, 1'b0, '0, '0);
         n_vec++;
         if (bus.entrada !== exp_w[i]) begin
            $display("FAIL oor_write[%0d]: got %0d expected %0d", i, bus.entrada, exp_w[i]); n_miss++;
         end
      end
   endtask

   initial begin
      n_vec       = 0;
      n_miss      = 0;
      reset       = 1'b1;
      bus.Tx      = T_HOLD;
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.ultimo  = 3'd2;
      test_reset();
      test_legacy();
      test_hold_shiftl();
      test_reset_midpass();
      test_collision();
      test_wrap_point();
      test_back_to_back();
      test_oor_write();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
